// File: rtl/mips_pkg.sv
// Encodings shared by the MIPS state controller and the instruction decoder.
package mips_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EXEC1 = 2'b01,
    EXEC2 = 2'b10,
    HALT  = 2'b11
  } state_t;

  localparam int WAIT_LIMIT_DEF = 1024;

endpackage

// File: rtl/mips_wait_watchdog.sv
// Counts consecutive waitrequest cycles and flags when the bus has been stuck too long.
module mips_wait_watchdog
  import mips_pkg::*;
#(
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic waitrequest,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(WAIT_LIMIT - 1);

  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (en && waitrequest) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Fires on the final tolerated stuck cycle so the controller halts at the next edge.
  assign expired = en && waitrequest && (wait_cnt == LAST);

endmodule

// File: rtl/mips_state_controller.sv
// Multi-cycle MIPS sequencer: FETCH/EXEC1/EXEC2/HALT with stalls, mult/div handshake,
// branch delay slot, retired-instruction counter and bus-stall watchdog.
module mips_state_controller
  import mips_pkg::*;
#(
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEF,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             waitrequest,
  input  logic             extra,
  input  logic             halt,
  input  logic             md_req,
  input  logic             md_done,
  input  logic             branch_taken,
  output logic [1:0]       state,
  output logic             md_start,
  output logic             stall,
  output logic             use_target,
  output logic             active,
  output logic             bus_timeout,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_n;
  logic             md_busy, md_busy_n;
  logic             delay_pending, delay_pending_n;
  logic             bus_timeout_n;
  logic [CNT_W-1:0] retired_n;
  logic             expired;

  mips_wait_watchdog #(.WAIT_LIMIT(WAIT_LIMIT)) u_watchdog (
    .clk         (clk),
    .reset       (reset),
    .waitrequest (waitrequest),
    .en          (state_q != HALT),
    .expired     (expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= FETCH;
      md_busy       <= 1'b0;
      delay_pending <= 1'b0;
      bus_timeout   <= 1'b0;
      retired       <= '0;
    end else begin
      state_q       <= state_n;
      md_busy       <= md_busy_n;
      delay_pending <= delay_pending_n;
      bus_timeout   <= bus_timeout_n;
      retired       <= retired_n;
    end
  end

  always_comb begin
    state_n         = state_q;
    md_busy_n       = md_busy;
    delay_pending_n = delay_pending;
    bus_timeout_n   = bus_timeout;
    retired_n       = retired;
    md_start        = 1'b0;
    use_target      = 1'b0;
    stall           = 1'b0;

    if (state_q != HALT && waitrequest) begin
      stall = 1'b1;
      if (expired) begin
        state_n       = HALT;
        bus_timeout_n = 1'b1;
      end
    end

    case (state_q)
      FETCH: begin
        if (halt) begin
          state_n = HALT;
        end else if (!waitrequest) begin
          state_n = EXEC1;
        end
      end
      EXEC1: begin
        if (waitrequest) begin
          // stay; watchdog handled above
        end else if (md_req && !md_busy) begin
          md_start  = 1'b1;
          md_busy_n = 1'b1;
        end else if (md_busy && !md_done) begin
          stall = 1'b1;
        end else begin
          md_busy_n = 1'b0;
          // A branch inside the delay slot is not supported and is dropped.
          if (branch_taken && !delay_pending) begin
            delay_pending_n = 1'b1;
          end
          if (extra) begin
            state_n = EXEC2;
          end else begin
            state_n   = FETCH;
            retired_n = retired + 1'b1;
            if (delay_pending) begin
              use_target      = 1'b1;
              delay_pending_n = 1'b0;
            end
          end
        end
      end
      EXEC2: begin
        if (!waitrequest) begin
          state_n   = FETCH;
          retired_n = retired + 1'b1;
          if (delay_pending) begin
            use_target      = 1'b1;
            delay_pending_n = 1'b0;
          end
        end
      end
      HALT: begin
        stall = 1'b1;
      end
    endcase

    // Nothing may escape to the PC or mult/div unit while reset is being sampled.
    if (!reset) begin
      md_start   = 1'b0;
      use_target = 1'b0;
    end
  end

  assign state  = state_q;
  assign active = (state_q != HALT);

endmodule
